// File: rtl/spi_bus_arb.sv
//==============================================================================
// Module      : spi_bus_arb
// Description : Locked, round-robin arbiter sharing one SPI master between the
//               A2D engine (A) and the inertial-sensor interface (B), with a
//               hold-time watchdog that evicts a stuck owner.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_bus_arb #(
    parameter int MAX_HOLD = 4096,
    parameter int HW       = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_wrt,
    input  logic [15:0] a_cmd,
    output logic        a_gnt,
    output logic        a_done,
    input  logic        b_req,
    input  logic        b_wrt,
    input  logic [15:0] b_cmd,
    output logic        b_gnt,
    output logic        b_done,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    output logic        tmo,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic          c_OWNER_A   = 1'b0;
    localparam logic          c_OWNER_B   = 1'b1;
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_owner;      // doubles as last_owner for the round-robin tie break
    logic            r_busy;
    logic [HW-1:0]   r_hold;

    logic            w_owning;
    logic            w_own_req;
    logic            w_own_wrt;
    logic [15:0]     w_own_cmd;
    logic            w_expire;
    logic            w_release;
    logic            w_grant;
    logic            w_grant_owner;

    always_comb begin
        w_owning  = (r_state == ST_OWN_A) || (r_state == ST_OWN_B);
        w_own_req = (r_owner == c_OWNER_B) ? b_req : a_req;
        w_own_wrt = w_owning && ((r_owner == c_OWNER_B) ? b_wrt : a_wrt);
        w_own_cmd = (r_owner == c_OWNER_B) ? b_cmd : a_cmd;
        w_release = w_owning && !w_own_req && !r_busy;
        w_expire  = w_owning && (r_hold == c_HOLD_LAST);
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    w_grant = 1'b1;
                    // On a tie the requester that did not own the bus last wins
                    if (a_req && b_req)
                        w_grant_owner = ~r_owner;
                    else
                        w_grant_owner = b_req ? c_OWNER_B : c_OWNER_A;
                    w_next_state = (w_grant_owner == c_OWNER_B) ? ST_OWN_B : ST_OWN_A;
                end
            end
            ST_OWN_A, ST_OWN_B: begin
                if (w_release)
                    w_next_state = ST_IDLE;
                else if (w_expire)
                    w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_busy || spi_done)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= c_OWNER_B;
            r_busy  <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant)
                r_owner <= w_grant_owner;
            if (spi_wrt)
                r_busy <= 1'b1;
            else if (spi_done)
                r_busy <= 1'b0;
            if (w_grant)
                r_hold <= '0;
            else if (w_owning && (r_hold != c_HOLD_LAST))
                r_hold <= r_hold + 1'b1;
        end
    end

    assign a_gnt     = (r_state == ST_OWN_A);
    assign b_gnt     = (r_state == ST_OWN_B);
    assign spi_wrt   = w_own_wrt && !r_busy;
    assign proto_err = w_own_wrt && r_busy;
    assign spi_cmd   = w_owning ? w_own_cmd : 16'h0000;
    // A voluntary release in the expiry cycle takes precedence over eviction
    assign tmo       = w_expire && !w_release;
    // Owner survives DRAIN, so a late completion still reaches the evicted side
    assign a_done    = spi_done && r_busy && (r_owner == c_OWNER_A);
    assign b_done    = spi_done && r_busy && (r_owner == c_OWNER_B);

endmodule

`default_nettype wire
